// File: rtl/alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// AluIssueArbiter
//
// Shares one multi-cycle ALU execution element between NREQ issue
// requesters. A round-robin arbiter picks a winner in IDLE and registers its
// operands into the alu_* outputs. The FSM then holds alu_start high for
// START_CYCLES cycles and waits for a rising edge on alu_completed. The
// result, or a zero result flagged as a timeout, goes back to the winner over
// a valid/ready response channel.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous active-low reset
//   req_valid      per-requester request pending
//   req_ready      per-requester request accepted this cycle (one-hot/zero)
//   req_inst_num   6-bit opcode per requester (slice i = requester i)
//   req_const16_x  32-bit immediate per requester
//   req_shift5     5-bit shift amount per requester
//   req_rs/req_rt  32-bit operands per requester
//   resp_valid     per-requester result available (one-hot/zero)
//   resp_ready     per-requester result consumed
//   resp_out       result of the current response
//   resp_timeout   current response timed out (resp_out is then zero)
//   busy           high whenever an operation is in flight
//   alu_start      start pulse to the element (drives its reset input)
//   alu_*          registered operands presented to the element
//   alu_completed  element done flag (only its rising edge counts)
//   alu_out        element result
// ---------------------------------------------------------------------------
module alu_issue_arbiter #(
    parameter int NREQ         = 2,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [6*NREQ-1:0]   req_inst_num,
    input  logic [32*NREQ-1:0]  req_const16_x,
    input  logic [5*NREQ-1:0]   req_shift5,
    input  logic [32*NREQ-1:0]  req_rs,
    input  logic [32*NREQ-1:0]  req_rt,
    output logic [NREQ-1:0]     resp_valid,
    input  logic [NREQ-1:0]     resp_ready,
    output logic [31:0]         resp_out,
    output logic                resp_timeout,
    output logic                busy,
    output logic                alu_start,
    output logic [5:0]          alu_inst_num,
    output logic [31:0]         alu_const16_x,
    output logic [4:0]          alu_shift5,
    output logic [31:0]         alu_rs,
    output logic [31:0]         alu_rt,
    input  logic                alu_completed,
    input  logic [31:0]         alu_out
);

    localparam int GW      = (NREQ > 2) ? 2 : 1;
    localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [GW-1:0] LAST_RESET = GW'(NREQ - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] lastGrant_q, lastGrant_d;
    logic [31:0]   result_q, result_d;
    logic          timedOut_q, timedOut_d;
    logic          comp_q;
    logic [5:0]    inst_q, inst_d;
    logic [31:0]   const_q, const_d;
    logic [4:0]    shift_q, shift_d;
    logic [31:0]   rs_q, rs_d;
    logic [31:0]   rt_q, rt_d;

    logic          anyValid;
    logic [GW-1:0] rrGrant;
    logic [GW-1:0] candIdx;
    logic          compEdge;

    // Round-robin search: start one past the last served requester and take
    // the first one with a pending request, so the requester just served has
    // the lowest priority next time.
    always_comb begin
        anyValid = 1'b0;
        rrGrant  = '0;
        candIdx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            candIdx = GW'((int'(lastGrant_q) + k) % NREQ);
            if (!anyValid && req_valid[candIdx]) begin
                anyValid = 1'b1;
                rrGrant  = candIdx;
            end
        end
    end

    // Only a fresh rising edge counts, so a completed level left over from the
    // previous operation can never be mistaken for completion of this one.
    assign compEdge = alu_completed & ~comp_q;

    // Next-state and request-side logic. req_ready is combinational and only
    // ever raised in IDLE, which is why a request cannot be accepted in the
    // same cycle a response is consumed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        result_d    = result_q;
        timedOut_d  = timedOut_q;
        inst_d      = inst_q;
        const_d     = const_q;
        shift_d     = shift_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    req_ready[rrGrant] = 1'b1;
                    grant_d = rrGrant;
                    inst_d  = req_inst_num[int'(rrGrant)*6 +: 6];
                    const_d = req_const16_x[int'(rrGrant)*32 +: 32];
                    shift_d = req_shift5[int'(rrGrant)*5 +: 5];
                    rs_d    = req_rs[int'(rrGrant)*32 +: 32];
                    rt_d    = req_rt[int'(rrGrant)*32 +: 32];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                // Completion is tested first so it wins over a timeout
                // landing in the same cycle.
                if (compEdge) begin
                    result_d   = alu_out;
                    timedOut_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = RESP;
                end else if (cnt_q == WAIT_LAST) begin
                    result_d   = '0;
                    timedOut_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (resp_ready[grant_q]) begin
                    lastGrant_d = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset abandons any operation in flight; because
    // alu_start and the response outputs decode from the state, they drop
    // as soon as reset goes low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            lastGrant_q <= LAST_RESET;
            result_q    <= '0;
            timedOut_q  <= 1'b0;
            comp_q      <= 1'b0;
            inst_q      <= '0;
            const_q     <= '0;
            shift_q     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            result_q    <= result_d;
            timedOut_q  <= timedOut_d;
            comp_q      <= alu_completed;
            inst_q      <= inst_d;
            const_q     <= const_d;
            shift_q     <= shift_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
        end
    end

    // Response channel: all three outputs are held for as long as RESP lasts
    // and read zero otherwise.
    always_comb begin
        resp_valid   = '0;
        resp_out     = '0;
        resp_timeout = 1'b0;
        if (state_q == RESP) begin
            resp_valid[grant_q] = 1'b1;
            resp_out            = result_q;
            resp_timeout        = timedOut_q;
        end
    end

    assign busy          = (state_q != IDLE);
    assign alu_start     = (state_q == START);
    assign alu_inst_num  = inst_q;
    assign alu_const16_x = const_q;
    assign alu_shift5    = shift_q;
    assign alu_rs        = rs_q;
    assign alu_rt        = rt_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for alu_issue_arbiter.
// Contains a simple multi-cycle ALU element model that raises alu_completed
// a programmable number of cycles after alu_start falls (or never, or holds
// it high permanently). The arbiter is checked every cycle against a
// transaction-level model that predicts grants, response timing and results.
// ---------------------------------------------------------------------------
module tb_alu_issue_arbiter;

    localparam int NREQ         = 2;
    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 64;

    localparam logic [5:0] OP_SLL  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd8;
    localparam logic [5:0] OP_SUB  = 6'd9;
    localparam logic [5:0] OP_AND  = 6'd12;
    localparam logic [5:0] OP_XOR  = 6'd14;
    localparam logic [5:0] OP_LUI  = 6'd15;
    localparam logic [5:0] OP_MULT = 6'd24;
    localparam logic [5:0] OP_DIV  = 6'd26;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [6*NREQ-1:0]   req_inst_num;
    logic [32*NREQ-1:0]  req_const16_x;
    logic [5*NREQ-1:0]   req_shift5;
    logic [32*NREQ-1:0]  req_rs;
    logic [32*NREQ-1:0]  req_rt;
    logic [NREQ-1:0]     resp_valid;
    logic [NREQ-1:0]     resp_ready;
    logic [31:0]         resp_out;
    logic                resp_timeout;
    logic                busy;
    logic                alu_start;
    logic [5:0]          alu_inst_num;
    logic [31:0]         alu_const16_x;
    logic [4:0]          alu_shift5;
    logic [31:0]         alu_rs;
    logic [31:0]         alu_rt;
    logic                alu_completed;
    logic [31:0]         alu_out;

    alu_issue_arbiter #(
        .NREQ(NREQ),
        .START_CYCLES(START_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_inst_num(req_inst_num),
        .req_const16_x(req_const16_x),
        .req_shift5(req_shift5),
        .req_rs(req_rs),
        .req_rt(req_rt),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_out(resp_out),
        .resp_timeout(resp_timeout),
        .busy(busy),
        .alu_start(alu_start),
        .alu_inst_num(alu_inst_num),
        .alu_const16_x(alu_const16_x),
        .alu_shift5(alu_shift5),
        .alu_rs(alu_rs),
        .alu_rt(alu_rt),
        .alu_completed(alu_completed),
        .alu_out(alu_out)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element behaviour: 0 = completes elemLat cycles after start falls,
    // 1 = never completes, 2 = completed held high permanently.
    int   elemMode = 0;
    int   elemLat  = 1;
    int   elemCnt;
    logic elemActive;

    function automatic logic [31:0] elemCompute(logic [5:0] op, logic [31:0] c16,
                                                logic [4:0] sh, logic [31:0] rs,
                                                logic [31:0] rt);
        case (op)
            OP_ADD:  return rs + rt;
            OP_SUB:  return rs - rt;
            OP_AND:  return rs & rt;
            OP_XOR:  return rs ^ rt;
            OP_LUI:  return {c16[15:0], 16'h0000};
            OP_MULT: return rs * rt;
            OP_DIV:  return (rt == 0) ? 32'd0 : rs / rt;
            default: return rt << sh;
        endcase
    endfunction

    // Element model: restarts on every alu_start cycle and signals completion
    // from the operands the arbiter actually presents.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_completed <= 1'b0;
            alu_out       <= '0;
            elemActive    <= 1'b0;
            elemCnt       <= 0;
        end else if (alu_start) begin
            elemActive    <= (elemMode == 0);
            elemCnt       <= 0;
            alu_completed <= (elemMode == 2);
        end else if (elemMode == 2) begin
            alu_completed <= 1'b1;
        end else if (elemActive) begin
            if (elemCnt + 1 == elemLat) begin
                alu_completed <= 1'b1;
                alu_out       <= elemCompute(alu_inst_num, alu_const16_x, alu_shift5,
                                             alu_rs, alu_rt);
                elemActive    <= 1'b0;
            end else begin
                elemCnt <= elemCnt + 1;
            end
        end
    end

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    // Transaction model state.
    bit          mBusy;
    int          mOwner, mAccept, mRespCycle, mLast;
    logic [31:0] mResult;
    bit          mTimeout;
    logic [5:0]  mInst;
    logic [31:0] mC16, mRs, mRt;
    logic [4:0]  mSh;
    int          servedQ[$];
    logic [31:0] respLog[$];
    bit          toLog[$];
    int          lastHandshake, lastAcceptCyc, lastAcceptReq;
    bit [NREQ-1:0] autoDrop;

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setReq(int i, logic [5:0] op, logic [31:0] c16, logic [4:0] sh,
                          logic [31:0] rs, logic [31:0] rt);
        req_inst_num[i*6 +: 6]    = op;
        req_const16_x[i*32 +: 32] = c16;
        req_shift5[i*5 +: 5]      = sh;
        req_rs[i*32 +: 32]        = rs;
        req_rt[i*32 +: 32]        = rt;
    endtask

    // Compare one cycle of DUT outputs with the model, update the model with
    // any handshake seen, then advance to the next falling edge.
    task automatic checkOutput();
        int              win;
        int              acc;
        int              compOff;
        int              toOff;
        logic [NREQ-1:0] expReady;
        logic [NREQ-1:0] expValid;
        #1;
        acc = -1;
        if (!reset) begin
            checkVal("rst_busy", busy, 0);
            checkVal("rst_req_ready", req_ready, 0);
            checkVal("rst_resp_valid", resp_valid, 0);
            checkVal("rst_resp_out", resp_out, 0);
            checkVal("rst_resp_timeout", resp_timeout, 0);
            checkVal("rst_alu_start", alu_start, 0);
            checkVal("rst_alu_inst", alu_inst_num, 0);
            checkVal("rst_alu_const", alu_const16_x, 0);
            checkVal("rst_alu_shift", alu_shift5, 0);
            checkVal("rst_alu_rs", alu_rs, 0);
            checkVal("rst_alu_rt", alu_rt, 0);
            mBusy = 0;
            mLast = NREQ - 1;
        end else begin
            expReady = '0;
            win      = -1;
            if (!mBusy) begin
                for (int d = 1; d <= NREQ; d++) begin
                    if (win < 0 && req_valid[(mLast + d) % NREQ]) win = (mLast + d) % NREQ;
                end
            end
            if (win >= 0) expReady[win] = 1'b1;
            checkVal("req_ready", req_ready, expReady);
            checkVal("busy", busy, mBusy);
            checkVal("alu_start", alu_start,
                     mBusy && (cyc - mAccept) >= 1 && (cyc - mAccept) <= START_CYCLES);
            if (mBusy) begin
                expValid = '0;
                if (cyc >= mRespCycle) expValid[mOwner] = 1'b1;
                checkVal("resp_valid", resp_valid, expValid);
                checkVal("alu_inst_hold", alu_inst_num, mInst);
                checkVal("alu_const_hold", alu_const16_x, mC16);
                checkVal("alu_shift_hold", alu_shift5, mSh);
                checkVal("alu_rs_hold", alu_rs, mRs);
                checkVal("alu_rt_hold", alu_rt, mRt);
                if (expValid != 0) begin
                    checkVal("resp_out", resp_out, mResult);
                    checkVal("resp_timeout", resp_timeout, mTimeout);
                    if (resp_ready[mOwner]) begin
                        mBusy = 0;
                        mLast = mOwner;
                        servedQ.push_back(mOwner);
                        respLog.push_back(resp_out);
                        toLog.push_back(resp_timeout);
                        lastHandshake = cyc;
                    end
                end
            end else begin
                checkVal("resp_valid_idle", resp_valid, 0);
            end
            if (win >= 0) begin
                mBusy   = 1;
                mOwner  = win;
                mAccept = cyc;
                mInst   = req_inst_num[win*6 +: 6];
                mC16    = req_const16_x[win*32 +: 32];
                mSh     = req_shift5[win*5 +: 5];
                mRs     = req_rs[win*32 +: 32];
                mRt     = req_rt[win*32 +: 32];
                compOff = START_CYCLES + 1 + elemLat;
                toOff   = START_CYCLES + TIMEOUT;
                if (elemMode == 0 && compOff <= toOff) begin
                    mRespCycle = cyc + compOff + 1;
                    mResult    = elemCompute(mInst, mC16, mSh, mRs, mRt);
                    mTimeout   = 0;
                end else begin
                    mRespCycle = cyc + toOff + 1;
                    mResult    = '0;
                    mTimeout   = 1;
                end
                acc           = win;
                lastAcceptCyc = cyc;
                lastAcceptReq = win;
            end
        end
        @(negedge clk);
        cyc++;
        if (acc >= 0 && autoDrop[acc]) req_valid[acc] = 1'b0;
    endtask

    task automatic clearLogs();
        servedQ.delete();
        respLog.delete();
        toLog.delete();
    endtask

    task automatic runUntil(int nServed, int budget);
        int n = 0;
        while (servedQ.size() < nServed && n < budget) begin
            checkOutput();
            n++;
        end
        checkVal("served_count", servedQ.size(), nServed);
    endtask

    task automatic applyStimulus();
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        checkOutput();
        checkOutput();
        reset = 1'b1;
        clearLogs();
    endtask

    function automatic int servedAt(int i);
        return (servedQ.size() > i) ? servedQ[i] : -1;
    endfunction

    function automatic logic [31:0] respAt(int i);
        return (respLog.size() > i) ? respLog[i] : 32'hdeadbeef;
    endfunction

    typedef struct {
        int          req;
        logic [5:0]  op;
        logic [31:0] c16;
        logic [4:0]  sh;
        logic [31:0] rs;
        logic [31:0] rt;
        int          mode;
        int          lat;
        logic [31:0] expOut;
        bit          expTo;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int r;
        int n;
        logic [5:0] opList[8];

        vecs[0]  = '{0, OP_ADD,  32'h0,    5'd0,  32'd17,    32'd255,   0, 1,  32'h00000110, 1'b0};
        vecs[1]  = '{0, OP_SUB,  32'h0,    5'd0,  32'd17,    32'd18,    0, 2,  32'hffffffff, 1'b0};
        vecs[2]  = '{1, OP_LUI,  32'h35f1, 5'd0,  32'd0,     32'd0,     0, 1,  32'h35f10000, 1'b0};
        vecs[3]  = '{0, OP_MULT, 32'h0,    5'd0,  32'hdab,   32'heae,   0, 4,  32'd13149242, 1'b0};
        vecs[4]  = '{1, OP_XOR,  32'h0,    5'd0,  32'd3,     32'd5,     0, 3,  32'd6,        1'b0};
        vecs[5]  = '{1, OP_AND,  32'h0,    5'd0,  32'hf0f0,  32'h3c3c,  0, 2,  32'h00003030, 1'b0};
        vecs[6]  = '{0, OP_DIV,  32'h0,    5'd0,  32'd100,   32'd7,     0, 63, 32'd14,       1'b0};
        vecs[7]  = '{1, OP_DIV,  32'h0,    5'd0,  32'd100,   32'd7,     0, 64, 32'd0,        1'b1};
        vecs[8]  = '{0, OP_ADD,  32'h0,    5'd0,  32'd1,     32'd2,     1, 1,  32'd0,        1'b1};
        vecs[9]  = '{1, OP_ADD,  32'h0,    5'd0,  32'd1,     32'd2,     2, 1,  32'd0,        1'b1};
        vecs[10] = '{0, OP_SLL,  32'h0,    5'd31, 32'd0,     32'd1,     0, 1,  32'h80000000, 1'b0};
        opList = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LUI, OP_MULT, OP_DIV, OP_SLL};

        reset         = 1'b1;
        req_valid     = '0;
        resp_ready    = '0;
        req_inst_num  = '0;
        req_const16_x = '0;
        req_shift5    = '0;
        req_rs        = '0;
        req_rt        = '0;
        autoDrop      = '1;
        mBusy         = 0;
        mLast         = NREQ - 1;
        #2 reset = 1'b0;
        @(negedge clk);
        applyStimulus();

        // Table of single operations, including both sides of the timeout
        // boundary and the two kinds of misbehaving element.
        resp_ready = '1;
        for (int v = 0; v < 11; v++) begin
            clearLogs();
            elemMode = vecs[v].mode;
            elemLat  = vecs[v].lat;
            setReq(vecs[v].req, vecs[v].op, vecs[v].c16, vecs[v].sh, vecs[v].rs, vecs[v].rt);
            req_valid[vecs[v].req] = 1'b1;
            runUntil(1, 200);
            checkVal($sformatf("vec%0d_owner", v), servedAt(0), vecs[v].req);
            checkVal($sformatf("vec%0d_out", v), respAt(0), vecs[v].expOut);
            checkVal($sformatf("vec%0d_timeout", v), (toLog.size() > 0) ? toLog[0] : 1'bx,
                     vecs[v].expTo);
        end
        elemMode = 0;

        // Contention: both requesters at once, then both again.
        applyStimulus();
        resp_ready = '1;
        elemLat    = 2;
        setReq(0, OP_SUB, 32'h0, 5'd0, 32'd17, 32'd18);
        setReq(1, OP_LUI, 32'h35f1, 5'd0, 32'd0, 32'd0);
        req_valid = 2'b11;
        runUntil(2, 300);
        checkVal("cont_first", servedAt(0), 0);
        checkVal("cont_second", servedAt(1), 1);
        checkVal("cont_out0", respAt(0), 32'hffffffff);
        checkVal("cont_out1", respAt(1), 32'h35f10000);
        clearLogs();
        req_valid = 2'b11;
        runUntil(2, 300);
        checkVal("cont_reissue_first", servedAt(0), 0);
        checkVal("cont_reissue_second", servedAt(1), 1);

        // Fairness: requester 1 never drops its request, requester 0 keeps
        // re-issuing, so grants must alternate.
        applyStimulus();
        resp_ready = '1;
        elemLat    = 1;
        autoDrop   = 2'b01;
        setReq(1, OP_AND, 32'h0, 5'd0, 32'hff00ff00, 32'h0ff00ff0);
        req_valid[1] = 1'b1;
        n = 0;
        while (servedQ.size() < 4 && n < 400) begin
            if (!req_valid[0]) begin
                setReq(0, OP_AND, 32'h0, 5'd0, $urandom, $urandom);
                req_valid[0] = 1'b1;
            end
            checkOutput();
            n++;
        end
        req_valid = '0;
        autoDrop  = '1;
        for (int i = 0; i < 4; i++) checkVal($sformatf("fair_grant%0d", i), servedAt(i), i % 2);

        // Backpressure: the response is stalled, the other requester's ready
        // is ignored and a new request waits for the cycle after the handshake.
        applyStimulus();
        elemLat    = 3;
        resp_ready = '0;
        setReq(0, OP_MULT, 32'h0, 5'd0, 32'hdab, 32'heae);
        req_valid[0] = 1'b1;
        n = 0;
        while (resp_valid == 0 && n < 100) begin
            checkOutput();
            n++;
        end
        checkVal("bp_resp_seen", resp_valid, 2'b01);
        setReq(1, OP_XOR, 32'h0, 5'd0, 32'd3, 32'd5);
        req_valid[1] = 1'b1;
        resp_ready   = 2'b10;
        repeat (5) checkOutput();
        checkVal("bp_still_busy", servedQ.size(), 0);
        resp_ready = 2'b01;
        checkOutput();
        checkOutput();
        checkVal("bp_accept_req", lastAcceptReq, 1);
        checkVal("bp_accept_delay", lastAcceptCyc - lastHandshake, 1);
        checkVal("bp_out", respAt(0), 32'd13149242);
        resp_ready = '1;
        runUntil(2, 100);
        checkVal("bp_second_out", respAt(1), 32'd6);

        // Reset in the middle of a long wait abandons the operation.
        applyStimulus();
        resp_ready = '1;
        elemLat    = 30;
        setReq(0, OP_DIV, 32'h0, 5'd0, 32'd1000, 32'd10);
        req_valid[0] = 1'b1;
        repeat (START_CYCLES + 4) checkOutput();
        checkVal("mid_busy_before", busy, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkVal("mid_busy", busy, 0);
        checkVal("mid_alu_start", alu_start, 0);
        checkVal("mid_resp_valid", resp_valid, 0);
        checkVal("mid_alu_rs", alu_rs, 0);
        checkVal("mid_alu_inst", alu_inst_num, 0);
        @(negedge clk);
        checkOutput();
        reset = 1'b1;
        clearLogs();
        elemLat   = 2;
        req_valid = '0;
        setReq(1, OP_XOR, 32'h0, 5'd0, 32'd3, 32'd5);
        req_valid[1] = 1'b1;
        runUntil(1, 100);
        checkVal("mid_after_owner", servedAt(0), 1);
        checkVal("mid_after_out", respAt(0), 32'd6);

        // Randomised traffic with random backpressure and element behaviour.
        clearLogs();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    setReq(i, opList[$urandom_range(7)], $urandom, 5'($urandom), $urandom, $urandom);
                    req_valid[i] = 1'b1;
                end
            end
            resp_ready = NREQ'($urandom);
            if (!mBusy) begin
                r        = $urandom_range(19);
                elemMode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
                elemLat  = $urandom_range(6, 1);
            end
            checkOutput();
        end
        req_valid  = '0;
        resp_ready = '1;
        n = 0;
        while (mBusy && n < 200) begin
            checkOutput();
            n++;
        end
        checkVal("rand_drained", mBusy, 0);
        checkVal("rand_some_served", servedQ.size() > 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one multi-cycle AluExecElement between NREQ issue requesters.
- Arbitrates round-robin and registers the winner's operands.
- Sequences the element's start pulse and waits for its completion edge.
- Returns the result to the winner over a valid/ready response channel, with a timeout guard.

Parameters:
NREQ, 2, number of requesters (2..4)
START_CYCLES, 2, cycles alu_start is held high per operation (>=1)
TIMEOUT, 64, max WAIT cycles before forced timeout response (>=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; low clears all state immediately
req_valid  in  NREQ  request pending, per requester
req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
req_inst_num  in  6*NREQ  opcode, slice i belongs to requester i
req_const16_x  in  32*NREQ  immediate
req_shift5  in  5*NREQ  shift amount
req_rs  in  32*NREQ  operand rs
req_rt  in  32*NREQ  operand rt
resp_valid  out  NREQ  result available, one-hot or zero
resp_ready  in  NREQ  requester consumes result
resp_out  out  32  result, meaningful while any resp_valid high
resp_timeout  out  1  qualifies resp_valid: operation timed out, resp_out = 0
busy  out  1  high in any state except IDLE
alu_start  out  1  drives element reset input (active-high start)
alu_inst_num  out  6  registered operand to element
alu_const16_x  out  32  registered operand
alu_shift5  out  5  registered operand
alu_rs  out  32  registered operand
alu_rt  out  32  registered operand
alu_completed  in  1  element done flag
alu_out  in  32  element result

Behaviour:
- States:
  - IDLE: no operation in progress.
  - START: element start pulse asserted.
  - WAIT: waiting for element completion.
  - RESP: result held for the winning requester.
- Reset (low):
  - state = IDLE.
  - All outputs = 0, including alu_start and the alu_* operand registers.
  - last_grant = NREQ-1, so requester 0 has first priority.
  - Counters = 0; comp_q = 0.
- IDLE:
  - If any req_valid, grant g = first requester with req_valid set, searching from last_grant+1 modulo NREQ.
  - req_ready[g] is combinational and high only in IDLE for g.
  - On the clock edge: latch slice g into the alu_* registers, store g, -> START.
  - No req_valid: stay in IDLE, req_ready = 0.
- START:
  - alu_start = 1 for exactly START_CYCLES cycles, counted by cnt.
  - Then -> WAIT with alu_start = 0 and cnt cleared.
- WAIT:
  - comp_q is alu_completed registered every cycle in every state.
  - Completion = alu_completed & ~comp_q (rising edge) observed in WAIT.
  - A level left high from the previous operation is never taken as completion.
  - On completion: result <= alu_out, timeout flag <= 0, -> RESP.
  - Otherwise cnt increments. When cnt reaches TIMEOUT-1 with no edge: result <= 0, timeout flag <= 1, -> RESP.
  - If completion and timeout fall in the same cycle, completion wins.
- RESP:
  - resp_valid[g] = 1, resp_out = result, resp_timeout = flag.
  - All three are held stable until resp_ready[g] = 1.
  - On that edge: last_grant <= g, -> IDLE.
  - resp_ready of other requesters is ignored.
  - A new request cannot be accepted in the cycle the response is consumed; earliest acceptance is the next IDLE cycle.
- alu_* operands stay stable from START through RESP; they change only on an IDLE grant.
- Latency with request accepted at cycle 0 and completion edge at cycle 0+START_CYCLES+k (k>=1):
  - resp_valid rises at cycle START_CYCLES+k+1.
  - With resp_ready held high, IDLE is re-entered one cycle later.
- req_valid changing while not in IDLE has no effect.
- Reset asserted mid-operation:
  - The operation is abandoned and no response is produced.
  - alu_start drops asynchronously.
- Result width is 32 bits; no extension or masking is applied to alu_out.

Test Plan:
- Single ADD: req 0 inst 8, rs=17, rt=255 -> alu_start high 2 cycles; resp_valid[0] with resp_out=0x00000110, resp_timeout=0; req_ready[0] pulsed exactly one cycle.
- Contention: both valid at once; req0 SUB(17,18), req1 LUI const=0x35f1 -> req0 served first with 0xffffffff, then req1 with 0x35f10000. Both re-issued -> req0 wins again (last_grant=1).
- Round-robin fairness: req1 held valid continuously while req0 reissues ANDs -> grants strictly alternate 0,1,0,1 over 4 operations; no requester served twice in a row while the other waits.
- Backpressure: MULT 0xdab*0xeae, resp_ready low 5 cycles -> resp_valid, resp_out=13149242 and alu_* stable throughout; a new req_valid is not accepted until one cycle after the handshake.
- Timeout: element model never raises alu_completed (or holds it high continuously from before start) -> after TIMEOUT WAIT cycles, resp_valid with resp_timeout=1, resp_out=0.
- Reset mid-WAIT: reset low during DIV wait -> all outputs 0 in the same cycle, busy=0; after release, req1 alone XOR(3,5) -> resp_out=6.
